line_burst_adaptor: RTL and testbench
=====================================

Name: line_burst_adaptor

Overview:
- Sits between cache_control's datapath and physical memory.
- Converts one 256-bit cacheline read or write request (pmem_read/pmem_write handshake) into a 4-beat, 64-bit burst transaction on the memory bus.
- Reassembles read beats into a full line and returns it with a single-cycle response.
- Serves allocate (line fill) and write-back traffic.

Parameters:
LINE_WIDTH, 256, cacheline width in bits
BURST_WIDTH, 64, memory beat width in bits; LINE_WIDTH must be a multiple of it
ADDR_WIDTH, 32, byte address width
TIMEOUT_CYCLES, 1024, watchdog limit (used only with ADAPTOR_TIMEOUT_EN)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
line_i  input  LINE_WIDTH  write-back line from cache
line_o  output  LINE_WIDTH  assembled fill line; valid while resp_o=1
address_i  input  ADDR_WIDTH  line address from cache
read_i  input  1  line read request (cache pmem_read)
write_i  input  1  line write request (cache pmem_write)
resp_o  output  1  one-cycle completion pulse (cache pmem_resp)
burst_i  input  BURST_WIDTH  read beat from memory
burst_o  output  BURST_WIDTH  write beat to memory
address_o  output  ADDR_WIDTH  burst address to memory
read_o  output  1  burst read request
write_o  output  1  burst write request
resp_i  input  1  memory beat accept/valid strobe
error_o  output  1  watchdog error (tied 0 without ADAPTOR_TIMEOUT_EN)

Behaviour:
- Constants:
  - BEATS = LINE_WIDTH/BURST_WIDTH (4).
  - Beat counter is $clog2(BEATS) bits (2).
  - OFFSET_BITS = $clog2(LINE_WIDTH/8) (5).
- State machine: S_IDLE, S_READ, S_WRITE, S_DONE.
- S_IDLE:
  - On a cycle with write_i=1, latch line_i into the line buffer, latch address_i with its low OFFSET_BITS forced to 0, clear the beat counter, and go to S_WRITE.
  - Else if read_i=1, latch the address the same way, clear the counter, and go to S_READ.
  - write_i has priority when both are high.
  - resp_i is ignored in S_IDLE.
- S_READ:
  - read_o=1 and address_o=latched address, held constant for the whole burst.
  - Each cycle with resp_i=1 writes burst_i into line buffer slice [cnt*BURST_WIDTH +: BURST_WIDTH] and increments cnt.
  - Gaps (resp_i=0) are allowed and stall the count.
  - The cycle that accepts beat BEATS-1 transitions to S_DONE.
- S_WRITE:
  - write_o=1 and address_o=latched address.
  - burst_o = line buffer slice [cnt*BURST_WIDTH +: BURST_WIDTH], combinational on cnt.
  - Each resp_i=1 cycle consumes one beat and increments cnt.
  - The cycle that consumes beat BEATS-1 transitions to S_DONE.
- S_DONE:
  - resp_o=1 for exactly one cycle; line_o = line buffer (fill data for reads, stale for writes).
  - read_o=write_o=0. Next state is S_IDLE unconditionally.
  - read_i/write_i are not sampled in S_DONE. The cache drops its request after seeing resp_o, so no request is double-issued.
- Latency:
  - Request seen in S_IDLE at cycle 0; read_o/write_o high from cycle 1.
  - With back-to-back beats, resp_i occurs in cycles 1–4 and resp_o in cycle 5.
  - Minimum line round trip is 6 cycles including return to S_IDLE.
- Outputs are low outside their states. address_o=0 and burst_o=0 in S_IDLE and S_DONE.
- Requests must remain stable until resp_o. A request deasserted mid-burst is ignored; the burst completes.
- Reset (also mid-burst): state=S_IDLE, cnt=0, line buffer=0, address=0, all outputs 0 on the next edge. The memory model is reset by the same rst.

Optional Feature:
- Macro: ADAPTOR_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to S_READ/S_WRITE and on every resp_i.
  - If it reaches TIMEOUT_CYCLES while in a burst state, error_o asserts (sticky until rst) and the FSM forces S_DONE, pulsing resp_o so the cache does not hang. Line data is undefined.
- Undefined: no counter is built, error_o is tied 0, and bursts wait indefinitely.

Decomposition:
- Shared package cache_types_pkg holds:
  - LINE_WIDTH, BURST_WIDTH, ADDR_WIDTH, and BEATS constants.
  - Typedefs line_t, burst_t, addr_t.
  - The adaptor state enum.
- One sub-module is natural: burst_beat_counter (count, clear, enable, last-beat flag), also reused by the watchdog.

Test Plan:
- Read fill: read_i, address_i=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles.
  -> address_o=0x0000_1220.
  -> resp_o pulses at cycle 5 with line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write-back: write_i, line_i = {0xD..D, 0xC..C, 0xB..B, 0xA..A}, address_i=0x8000_0040.
  -> burst_o = 0xA..A, 0xB..B, 0xC..C, 0xD..D in order on resp_i cycles; address_o=0x8000_0040.
  -> one resp_o pulse.
- Stalled beats: read with resp_i gaps of 3 idle cycles between beats.
  -> cnt advances only on resp_i; line is correct; resp_o occurs 1 cycle after the 4th beat.
- Simultaneous read_i=write_i=1.
  -> write burst is performed; read_o never asserts.
- Reset after beat 2 of a read.
  -> next cycle all outputs 0 and state idle; a fresh read completes correctly.
- ADAPTOR_TIMEOUT_EN, TIMEOUT_CYCLES=16, memory silent.
  -> error_o=1 and resp_o pulses 16 cycles after the last activity; error_o stays 1 until rst.

Source files
------------

// File: rtl/cache_types_pkg.sv
// Shared cacheline/burst types and adaptor state encoding.
// No ports; imported by the adaptor, its interfaces and the counter.
package cache_types_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int ADDR_WIDTH  = 32;
  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_W       = $clog2(BEATS);
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);

  typedef logic [LINE_WIDTH-1:0]  line_t;
  typedef logic [BURST_WIDTH-1:0] burst_t;
  typedef logic [ADDR_WIDTH-1:0]  addr_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } adaptor_state_t;

  function automatic addr_t line_align(input addr_t a);
    return {a[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/line_burst_adaptor_if.sv
// Cache-side line request bus and memory-side burst bus.
// cache_line_if: master = cache, slave = adaptor.
// mem_burst_if:  master = adaptor, slave = memory.
import cache_types_pkg::*;

interface cache_line_if;
  line_t line_i;
  line_t line_o;
  addr_t address_i;
  logic  read_i;
  logic  write_i;
  logic  resp_o;

  modport master (
    output line_i, address_i, read_i, write_i,
    input  line_o, resp_o
  );
  modport slave (
    input  line_i, address_i, read_i, write_i,
    output line_o, resp_o
  );
endinterface

interface mem_burst_if;
  burst_t burst_i;
  burst_t burst_o;
  addr_t  address_o;
  logic   read_o;
  logic   write_o;
  logic   resp_i;

  modport master (
    output burst_o, address_o, read_o, write_o,
    input  burst_i, resp_i
  );
  modport slave (
    input  burst_o, address_o, read_o, write_o,
    output burst_i, resp_i
  );
endinterface

// File: rtl/burst_beat_counter.sv
// Wrapping up-counter with clear/enable and a last-value flag.
// Ports: clk, rst, clr, en in; cnt, last (cnt == LIMIT-1) out.
module burst_beat_counter #(
  parameter int LIMIT = 4,
  parameter int W     = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         last
);

  localparam logic [W-1:0] MAX = W'(LIMIT - 1);

  assign last = (cnt == MAX);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/line_burst_adaptor.sv
// Turns one cacheline read/write into a 4-beat memory burst.
// Ports: clk, rst; cache (cache_line_if.slave); mem (mem_burst_if.master);
// error_o watchdog flag, only live with ADAPTOR_TIMEOUT_EN defined.
import cache_types_pkg::*;

module line_burst_adaptor #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  cache_line_if.slave  cache,
  mem_burst_if.master  mem,
  output logic         error_o
);

  adaptor_state_t   state;
  line_t            buf_q;
  addr_t            addr_q;
  logic             read_q;
  logic             write_q;
  logic             resp_q;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;
  logic             in_burst;
  logic             beat;
  logic             timeout;

  assign in_burst = (state == S_READ) || (state == S_WRITE);
  assign beat     = in_burst && mem.resp_i;

  burst_beat_counter #(
    .LIMIT (BEATS)
  ) u_beat_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == S_IDLE),
    .en   (beat),
    .cnt  (cnt),
    .last (cnt_last)
  );

`ifdef ADAPTOR_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WD_W-1:0] wd_cnt;
  logic            wd_last;
  logic            error_q;

  // Counts silent burst cycles; any accepted beat restarts the window.
  burst_beat_counter #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (WD_W)
  ) u_watchdog (
    .clk  (clk),
    .rst  (rst),
    .clr  ((state == S_IDLE) || mem.resp_i),
    .en   (in_burst),
    .cnt  (wd_cnt),
    .last (wd_last)
  );

  assign timeout = in_burst && wd_last && !mem.resp_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      error_q <= 1'b0;
    end else if (timeout) begin
      error_q <= 1'b1;
    end
  end

  assign error_o = error_q;
`else
  assign timeout = 1'b0;
  assign error_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      buf_q   <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cache.write_i) begin
            buf_q   <= cache.line_i;
            addr_q  <= line_align(cache.address_i);
            write_q <= 1'b1;
            state   <= S_WRITE;
          end else if (cache.read_i) begin
            addr_q <= line_align(cache.address_i);
            read_q <= 1'b1;
            state  <= S_READ;
          end
        end
        S_READ: begin
          if (mem.resp_i) begin
            buf_q[cnt*BURST_WIDTH +: BURST_WIDTH] <= mem.burst_i;
          end
          if (timeout || (mem.resp_i && cnt_last)) begin
            read_q <= 1'b0;
            resp_q <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_WRITE: begin
          if (timeout || (mem.resp_i && cnt_last)) begin
            write_q <= 1'b0;
            resp_q  <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          resp_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // read_q/write_q are high exactly while in the matching burst state.
  assign mem.read_o    = read_q;
  assign mem.write_o   = write_q;
  assign mem.address_o = (read_q || write_q) ? addr_q : '0;
  assign mem.burst_o   = write_q ? buf_q[cnt*BURST_WIDTH +: BURST_WIDTH] : '0;
  assign cache.resp_o  = resp_q;
  assign cache.line_o  = resp_q ? buf_q : '0;

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed table-driven bench for line_burst_adaptor.
// Covers fills, write-backs, stalls, priority, mid-burst reset, watchdog.
`timescale 1ns/1ps
import cache_types_pkg::*;

module tb_line_burst_adaptor;

  logic clk = 1'b0;
  logic rst;
  logic error_o;

  cache_line_if cif();
  mem_burst_if  mif();

  line_burst_adaptor #(
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cache   (cif.slave),
    .mem     (mif.master),
    .error_o (error_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic   rd;
    logic   wr;
    addr_t  addr;
    line_t  line;
    burst_t beat [4];
    int     gap;
    addr_t  exp_addr;
    line_t  exp_line;
  } vec_t;

  vec_t vecs [5];
  int   cmp  = 0;
  int   errs = 0;

  task automatic check(input string name,
                       input logic [255:0] act,
                       input logic [255:0] exp);
    cmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_read_o"},    mif.read_o, 0);
    check({tag, "_write_o"},   mif.write_o, 0);
    check({tag, "_address_o"}, mif.address_o, 0);
    check({tag, "_burst_o"},   mif.burst_o, 0);
    check({tag, "_resp_o"},    cif.resp_o, 0);
    check({tag, "_line_o"},    cif.line_o, 0);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    logic ew;
    logic er;
    v  = vecs[i];
    ew = v.wr;
    er = v.rd && !v.wr;
    cif.read_i    = v.rd;
    cif.write_i   = v.wr;
    cif.address_i = v.addr;
    cif.line_i    = v.line;
    tick();
    for (int b = 0; b < 4; b++) begin
      if (b > 0) begin
        for (int g = 0; g < v.gap; g++) begin
          mif.resp_i  = 1'b0;
          mif.burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
          check($sformatf("v%0d_stall_resp_o", i), cif.resp_o, 0);
          check($sformatf("v%0d_stall_read_o", i), mif.read_o, er);
          tick();
        end
      end
      check($sformatf("v%0d_b%0d_address_o", i, b), mif.address_o, v.exp_addr);
      check($sformatf("v%0d_b%0d_read_o", i, b), mif.read_o, er);
      check($sformatf("v%0d_b%0d_write_o", i, b), mif.write_o, ew);
      check($sformatf("v%0d_b%0d_resp_o", i, b), cif.resp_o, 0);
      if (ew) begin
        check($sformatf("v%0d_b%0d_burst_o", i, b), mif.burst_o, v.beat[b]);
      end
      mif.resp_i  = 1'b1;
      mif.burst_i = ew ? 64'h0 : v.beat[b];
      tick();
      mif.resp_i  = 1'b0;
      mif.burst_i = 64'h0;
    end
    check($sformatf("v%0d_done_resp_o", i), cif.resp_o, 1);
    check($sformatf("v%0d_done_read_o", i), mif.read_o, 0);
    check($sformatf("v%0d_done_write_o", i), mif.write_o, 0);
    check($sformatf("v%0d_done_address_o", i), mif.address_o, 0);
    if (er) begin
      check($sformatf("v%0d_line_o", i), cif.line_o, v.exp_line);
    end
    cif.read_i  = 1'b0;
    cif.write_i = 1'b0;
    tick();
    check_quiet($sformatf("v%0d_after", i));
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;

    vecs[0].rd = 1; vecs[0].wr = 0;
    vecs[0].addr = 32'h0000_1234;
    vecs[0].line = '0;
    vecs[0].beat = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                     64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    vecs[0].gap = 0;
    vecs[0].exp_addr = 32'h0000_1220;
    vecs[0].exp_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};

    vecs[1].rd = 0; vecs[1].wr = 1;
    vecs[1].addr = 32'h8000_0040;
    vecs[1].line = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                    64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    vecs[1].beat = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                     64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
    vecs[1].gap = 0;
    vecs[1].exp_addr = 32'h8000_0040;
    vecs[1].exp_line = '0;

    vecs[2].rd = 1; vecs[2].wr = 0;
    vecs[2].addr = 32'h0000_ABCF;
    vecs[2].line = '1;
    vecs[2].beat = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0};
    vecs[2].gap = 3;
    vecs[2].exp_addr = 32'h0000_ABC0;
    vecs[2].exp_line = {64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F,
                        64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};

    vecs[3].rd = 1; vecs[3].wr = 1;
    vecs[3].addr = 32'hFFFF_FFFF;
    vecs[3].line = {64'h4, 64'h3, 64'h2, 64'h1};
    vecs[3].beat = '{64'h1, 64'h2, 64'h3, 64'h4};
    vecs[3].gap = 1;
    vecs[3].exp_addr = 32'hFFFF_FFE0;
    vecs[3].exp_line = '0;

    vecs[4].rd = 0; vecs[4].wr = 1;
    vecs[4].addr = 32'h0000_0020;
    vecs[4].line = {64'h8877_6655_4433_2211, 64'h0,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'h5A5A_5A5A_5A5A_5A5A};
    vecs[4].beat = '{64'h5A5A_5A5A_5A5A_5A5A, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'h0, 64'h8877_6655_4433_2211};
    vecs[4].gap = 2;
    vecs[4].exp_addr = 32'h0000_0020;
    vecs[4].exp_line = '0;

    rst           = 1'b1;
    cif.read_i    = 1'b0;
    cif.write_i   = 1'b0;
    cif.address_i = '0;
    cif.line_i    = '0;
    mif.resp_i    = 1'b0;
    mif.burst_i   = '0;
    repeat (3) tick();
    check_quiet("reset");
    check("reset_error_o", error_o, 0);
    rst = 1'b0;

    // resp_i while idle must not start or advance anything
    mif.resp_i = 1'b1;
    tick();
    mif.resp_i = 1'b0;
    check_quiet("idle_resp");

    for (int i = 0; i < 5; i++) begin
      run_vec(i);
    end

    // Reset after two beats of a read, then a fresh read
    cif.read_i    = 1'b1;
    cif.address_i = 32'h0000_0100;
    tick();
    for (int b = 0; b < 2; b++) begin
      mif.resp_i  = 1'b1;
      mif.burst_i = 64'h9999_9999_9999_9999;
      tick();
    end
    mif.resp_i  = 1'b0;
    cif.read_i  = 1'b0;
    rst = 1'b1;
    tick();
    check_quiet("midrst");
    rst = 1'b0;
    tick();
    check_quiet("midrst_idle");
    run_vec(0);
    run_vec(2);

`ifdef ADAPTOR_TIMEOUT_EN
    cif.read_i    = 1'b1;
    cif.address_i = 32'h0000_0200;
    tick();
    lat = 1;
    while (!cif.resp_o && lat < 40) begin
      tick();
      lat++;
    end
    check("wd_resp_o", cif.resp_o, 1);
    check("wd_error_o", error_o, 1);
    check("wd_latency_16_18", (lat >= 16 && lat <= 18), 1);
    cif.read_i = 1'b0;
    tick();
    check("wd_read_o_low", mif.read_o, 0);
    run_vec(1);
    check("wd_error_sticky", error_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wd_error_cleared", error_o, 0);
`else
    lat = 0;
    check("error_o_tied", error_o, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
